pmod_adc_seq: RTL and testbench

Conversion sequencer for the Pmod ADC (MCP3002-type, 10-bit, 2-channel SPI) on the Tang Primer 9K. It generates CS/SCLK/MOSI, captures MISO, and delivers a 10-bit sample with a one-cycle valid strobe. Conversions are single-shot on request or free-running. It replaces the free-running `processCounter` sequencing in the sample top and feeds the seven-segment display driver.

---
 rtl/pmod_adc_seq.sv | 199 +++++++++++++++++++
 tb/tb_pmod_adc_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_adc_seq.sv
// Conversion sequencer for an MCP3002-style 10-bit, 2-channel SPI ADC.
// Drives CS/SCLK/MOSI in SPI mode 0 and shifts in MISO. Delivers each completed
// sample on data_o/ch_o together with a one-cycle valid_o strobe.
// Conversions are single-shot on request, or free-running while cont_i is high.
module pmod_adc_seq #(
   parameter int CLK_DIV = 8,   // sys_clk cycles per SCLK half-period, 2..255
   parameter int CS_IDLE = 16   // minimum CS-high cycles between frames, 1..255
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       start_i,
   input  logic       ch_i,
   input  logic       cont_i,
   output logic       busy_o,
   output logic       adc_cs_n_o,
   output logic       adc_sclk_o,
   output logic       adc_mosi_o,
   input  logic       adc_miso_i,
   output logic [9:0] data_o,
   output logic       ch_o,
   output logic       valid_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 1);
   localparam logic [5:0] PH_LAST  = 6'd31;

   state_t     state, state_nxt;
   logic [7:0] div_cnt, div_cnt_nxt;
   logic [5:0] ph, ph_nxt;
   logic [7:0] gap_cnt, gap_cnt_nxt;

   logic       cs_n_nxt, sclk_nxt, mosi_nxt, busy_nxt;
   logic       ch_lat;      // channel of the frame in flight
   logic       done_seen;   // a frame has completed since reset; enables free-run
   logic [9:0] shreg;

   logic       accept;
   logic       div_tc;
   logic       sample;

   // Command word sent on DIN, indexed by SCLK rise: start, SGL, channel, MSBF, then zeros.
   function automatic logic cmd_bit(input logic [3:0] r, input logic ch);
      case (r)
         4'd0, 4'd1, 4'd3: return 1'b1;
         4'd2:             return ch;
         default:          return 1'b0;
      endcase
   endfunction

   assign accept = start_i | (cont_i & done_seen);
   assign div_tc = (div_cnt == DIV_LAST);
   // MISO is taken in the first cycle after SCLK rises; only rises 5..14 carry B9..B0.
   assign sample = (state == SHIFT) && ph[0] && (div_cnt == 8'd0) &&
                   (ph[4:1] >= 4'd5) && (ph[4:1] <= 4'd14);

   // State register and sequencing counters.
   // NOTE: every clocked assignment is non-blocking so all registers update from
   // the same pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         div_cnt <= '0;
         ph      <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_cnt_nxt;
         ph      <= ph_nxt;
         gap_cnt <= gap_cnt_nxt;
      end
   end

   // Next-state and counter logic.
   // NOTE: each variable gets a default before the case so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_nxt   = state;
      div_cnt_nxt = div_cnt;
      ph_nxt      = ph;
      gap_cnt_nxt = gap_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt   = SETUP;
               div_cnt_nxt = '0;
            end
         end
         SETUP: begin
            if (div_tc) begin
               state_nxt   = SHIFT;
               div_cnt_nxt = '0;
               ph_nxt      = '0;
            end else begin
               div_cnt_nxt = div_cnt + 8'd1;
            end
         end
         SHIFT: begin
            if (div_tc) begin
               div_cnt_nxt = '0;
               if (ph == PH_LAST) begin
                  state_nxt = DONE;
                  ph_nxt    = '0;
               end else begin
                  ph_nxt = ph + 6'd1;
               end
            end else begin
               div_cnt_nxt = div_cnt + 8'd1;
            end
         end
         DONE: begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus and busy values for the coming cycle, derived from where the FSM is heading
   // so the registered outputs change on the same edge as the state.
   always_comb begin
      cs_n_nxt = 1'b1;
      sclk_nxt = 1'b0;
      mosi_nxt = 1'b0;
      busy_nxt = 1'b0;
      case (state_nxt)
         SETUP: begin
            cs_n_nxt = 1'b0;
            mosi_nxt = 1'b1;
            busy_nxt = 1'b1;
         end
         SHIFT: begin
            cs_n_nxt = 1'b0;
            sclk_nxt = ph_nxt[0];
            // Constant across an even/odd phase pair, so DIN only moves on SCLK falls.
            mosi_nxt = cmd_bit(ph_nxt[4:1], ch_lat);
            busy_nxt = 1'b1;
         end
         DONE: begin
            cs_n_nxt = 1'b0;
            busy_nxt = 1'b1;
         end
         GAP: begin
            busy_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   // Output registers, channel latch and MISO shift register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         adc_cs_n_o <= 1'b1;
         adc_sclk_o <= 1'b0;
         adc_mosi_o <= 1'b0;
         busy_o     <= 1'b0;
         valid_o    <= 1'b0;
         data_o     <= '0;
         ch_o       <= 1'b0;
         ch_lat     <= 1'b0;
         done_seen  <= 1'b0;
         shreg      <= '0;
      end else begin
         adc_cs_n_o <= cs_n_nxt;
         adc_sclk_o <= sclk_nxt;
         adc_mosi_o <= mosi_nxt;
         busy_o     <= busy_nxt;
         valid_o    <= (state == DONE);
         // A cont-only restart keeps the channel of the previous request.
         if (state == IDLE && start_i) begin
            ch_lat <= ch_i;
         end
         if (sample) begin
            shreg <= {shreg[8:0], adc_miso_i};
         end
         if (state == DONE) begin
            data_o    <= shreg;
            ch_o      <= ch_lat;
            done_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pmod_adc_seq.sv
// Self-checking bench for pmod_adc_seq. Two instances run side by side:
// lane 0 uses the default divider and gap, and lane 1 uses the minimum divider and gap.
// A behavioural ADC per lane answers each frame with a value from a table.
// The bench checks timing and data against figures computed from the frame
// rules: latency, SCLK period, command bits and gap length.
module tb_pmod_adc_seq;

   localparam int D0 = 8;
   localparam int I0 = 16;
   localparam int D1 = 2;
   localparam int I1 = 1;
   localparam int NF = 16;

   logic       clk;
   logic       rst_n;
   logic       start  [2];
   logic       ch_in  [2];
   logic       cont   [2];
   logic       miso   [2];
   logic       cs_n   [2];
   logic       sclk   [2];
   logic       mosi   [2];
   logic       busy   [2];
   logic       valid  [2];
   logic       ch_out [2];
   logic [9:0] data   [2];

   pmod_adc_seq #(.CLK_DIV(D0), .CS_IDLE(I0)) dut0 (
      .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start[0]), .ch_i(ch_in[0]),
      .cont_i(cont[0]), .busy_o(busy[0]), .adc_cs_n_o(cs_n[0]), .adc_sclk_o(sclk[0]),
      .adc_mosi_o(mosi[0]), .adc_miso_i(miso[0]), .data_o(data[0]), .ch_o(ch_out[0]),
      .valid_o(valid[0]));

   pmod_adc_seq #(.CLK_DIV(D1), .CS_IDLE(I1)) dut1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start[1]), .ch_i(ch_in[1]),
      .cont_i(cont[1]), .busy_o(busy[1]), .adc_cs_n_o(cs_n[1]), .adc_sclk_o(sclk[1]),
      .adc_mosi_o(mosi[1]), .adc_miso_i(miso[1]), .data_o(data[1]), .ch_o(ch_out[1]),
      .valid_o(valid[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge count; after edge N it reads N.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-lane bus observation and ADC behaviour.
   logic [9:0]  vtab  [2][NF];   // ADC answer for the n-th frame of each lane
   int          k     [2];       // SCLK rises seen in the current frame
   int          fs    [2];       // frames started (CS falls)
   int          vc    [2];       // valid_o high cycles seen
   int          cur   [2];
   int          last_rise [2];
   int          stab  [2];       // cycles since MOSI last moved
   int          cs_run[2];
   logic        p_cs  [2] = '{1'b1, 1'b1};
   logic        p_sclk[2];
   logic        p_mosi[2];
   int          vcyc  [2][NF];
   logic [9:0]  vdat  [2][NF];
   logic        vch   [2][NF];
   int          rises [2][NF];
   int          frise [2][NF];
   int          perr  [2][NF];
   int          mstab [2][NF];
   int          gap   [2][NF];
   int          scyc  [2][NF];
   logic [15:0] mword [2][NF];

   // Observe both lanes away from the active edge and drive MISO while SCLK is low.
   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         int         dv;
         logic [9:0] v;
         dv = (l == 0) ? D0 : D1;
         if (p_cs[l] === 1'b1 && cs_n[l] === 1'b0) begin
            cur[l] = fs[l] % NF;
            fs[l]++;
            k[l] = 0;
            gap[l][cur[l]]   = cs_run[l];
            scyc[l][cur[l]]  = cyc;
            mword[l][cur[l]] = '0;
            perr[l][cur[l]]  = 0;
            mstab[l][cur[l]] = 100000;
            rises[l][cur[l]] = 0;
            frise[l][cur[l]] = -1;
         end
         cs_run[l] = (cs_n[l] === 1'b1) ? cs_run[l] + 1 : 0;
         stab[l]   = (mosi[l] !== p_mosi[l]) ? 0 : stab[l] + 1;
         if (cs_n[l] === 1'b0 && sclk[l] === 1'b1 && p_sclk[l] === 1'b0) begin
            if (k[l] == 0) frise[l][cur[l]] = cyc;
            else if (cyc - last_rise[l] != 2 * dv) perr[l][cur[l]]++;
            last_rise[l] = cyc;
            k[l]++;
            mword[l][cur[l]] = {mword[l][cur[l]][14:0], mosi[l]};
            if (stab[l] < mstab[l][cur[l]]) mstab[l][cur[l]] = stab[l];
            rises[l][cur[l]] = k[l];
         end
         if (sclk[l] !== 1'b1) begin
            v = vtab[l][cur[l]];
            // Rises 5..14 carry B9..B0; every other rise sees a 1 so a misplaced window shows.
            miso[l] = (k[l] >= 5 && k[l] <= 14) ? v[4'(14 - k[l])] : 1'b1;
         end
         if (valid[l] === 1'b1) begin
            vcyc[l][vc[l] % NF] = cyc;
            vdat[l][vc[l] % NF] = data[l];
            vch[l][vc[l] % NF]  = ch_out[l];
            vc[l]++;
         end
         p_cs[l]   = cs_n[l];
         p_sclk[l] = sclk[l];
         p_mosi[l] = mosi[l];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic start_frame(input int l, input logic c, output int t);
      start[l] = 1'b1;
      ch_in[l] = c;
      step(1);
      t = cyc;
      start[l] = 1'b0;
      check($sformatf("accept_busy%0d", l), busy[l], 1'b1);
      check($sformatf("accept_cs%0d", l), cs_n[l], 1'b0);
   endtask

   task automatic wait_valid(input int l, input int target, input int budget);
      int n;
      n = 0;
      while (vc[l] < target && n < budget) begin
         step(1);
         n++;
      end
      check($sformatf("valid_timeout%0d_%0d", l, target), (vc[l] >= target), 1'b1);
   endtask

   // Whole-frame expectations: 16 rises at 2*D, first at +2*D, command bits,
   // DIN setup time, latency 33*D+1 and returned sample/channel.
   task automatic check_frame(input int l, input int f, input int vi, input logic c, input int dv);
      logic [15:0] exp_cmd;
      exp_cmd = 16'hD000 | (c ? 16'h2000 : 16'h0000);
      check($sformatf("rises%0d_%0d", l, f), rises[l][f], 16);
      check($sformatf("mosi_cmd%0d_%0d", l, f), mword[l][f], exp_cmd);
      check($sformatf("first_rise%0d_%0d", l, f), frise[l][f] - scyc[l][f], 2 * dv);
      check($sformatf("sclk_period%0d_%0d", l, f), perr[l][f], 0);
      check($sformatf("mosi_setup%0d_%0d", l, f), (mstab[l][f] >= dv), 1'b1);
      check($sformatf("latency%0d_%0d", l, f), vcyc[l][vi] - scyc[l][f], 33 * dv + 1);
      check($sformatf("data%0d_%0d", l, f), vdat[l][vi], vtab[l][f]);
      check($sformatf("ch%0d_%0d", l, f), vch[l][vi], c);
   endtask

   initial begin
      int   t;
      int   v;
      logic c;
      rst_n = 1'b1;
      for (int l = 0; l < 2; l++) begin
         start[l] = 1'b0;
         ch_in[l] = 1'b0;
         cont[l]  = 1'b0;
         miso[l]  = 1'b1;
         for (int f = 0; f < NF; f++) vtab[l][f] = 10'($urandom);
      end
      vtab[0][0] = 10'h2A5;
      vtab[0][1] = 10'h3FF;
      vtab[0][2] = 10'h000;
      vtab[0][6][9] = 1'b1;   // guarantees a nonzero data_o before the reset test

      #2 rst_n = 1'b0;
      step(3);
      for (int l = 0; l < 2; l++) begin
         check($sformatf("rst_cs%0d", l), cs_n[l], 1'b1);
         check($sformatf("rst_sclk%0d", l), sclk[l], 1'b0);
         check($sformatf("rst_mosi%0d", l), mosi[l], 1'b0);
         check($sformatf("rst_busy%0d", l), busy[l], 1'b0);
         check($sformatf("rst_valid%0d", l), valid[l], 1'b0);
         check($sformatf("rst_data%0d", l), data[l], 10'h000);
         check($sformatf("rst_ch%0d", l), ch_out[l], 1'b0);
      end
      rst_n = 1'b1;
      step(2);

      // Single shot on CH0 returning 0x2A5.
      start_frame(0, 1'b0, t);
      wait_valid(0, 1, 400);
      check_frame(0, 0, 0, 1'b0, D0);
      check("t1_valid_edge", vcyc[0][0] - t, 265);
      check("t1_cs_at_valid", cs_n[0], 1'b1);
      v = vcyc[0][0];
      step(1);
      check("t1_valid_one_cycle", valid[0], 1'b0);
      check("t1_valid_count", vc[0], 1);
      step(v + I0 - 1 - cyc);
      check("t1_busy_in_gap", busy[0], 1'b1);
      step(1);
      check("t1_busy_fall", busy[0], 1'b0);
      check("t1_data_held", data[0], 10'h2A5);
      step(2);

      // CH1 returning 0x3FF, then 0x000.
      for (int i = 1; i <= 2; i++) begin
         start_frame(0, 1'b1, t);
         wait_valid(0, i + 1, 400);
         check_frame(0, i, i, 1'b1, D0);
         step(I0 + 2);
      end

      // Free-run: cont only, start held low; cleared mid third frame.
      cont[0] = 1'b1;
      wait_valid(0, 4, 400);
      wait_valid(0, 5, 400);
      step(40);
      cont[0] = 1'b0;
      wait_valid(0, 6, 400);
      step(I0 + 40);
      check("fr_frames", fs[0], 6);
      check("fr_valids", vc[0], 6);
      check("fr_busy_end", busy[0], 1'b0);
      for (int f = 3; f <= 5; f++) check_frame(0, f, f, 1'b1, D0);
      check("fr_spacing_a", vcyc[0][4] - vcyc[0][3], 282);
      check("fr_spacing_b", vcyc[0][5] - vcyc[0][4], 282);
      check("fr_cs_high_a", (gap[0][4] >= I0 + 1), 1'b1);
      check("fr_cs_high_b", (gap[0][5] >= I0 + 1), 1'b1);

      // start_i (and ch_i) toggled at ph = 10 of an active frame.
      start_frame(0, 1'b0, t);
      step(t + 11 * D0 + 2 - cyc);
      start[0] = 1'b1;
      ch_in[0] = 1'b1;
      step(1);
      start[0] = 1'b0;
      wait_valid(0, 7, 400);
      step(I0 + 40);
      check("ign_frames", fs[0], 7);
      check("ign_valids", vc[0], 7);
      check("ign_busy_end", busy[0], 1'b0);
      check_frame(0, 6, 6, 1'b0, D0);

      // Reset at ph = 20, then a clean frame.
      c = 1'($urandom_range(0, 1));
      start_frame(0, c, t);
      step(t + 21 * D0 + 2 - cyc);
      rst_n = 1'b0;
      #1;
      check("mrst_cs", cs_n[0], 1'b1);
      check("mrst_sclk", sclk[0], 1'b0);
      check("mrst_busy", busy[0], 1'b0);
      check("mrst_data", data[0], 10'h000);
      step(3);
      rst_n = 1'b1;
      step(120);
      check("mrst_no_valid", vc[0], 7);
      check("mrst_data_after", data[0], 10'h000);
      check("mrst_idle_cs", cs_n[0], 1'b1);
      c = 1'($urandom_range(0, 1));
      start_frame(0, c, t);
      wait_valid(0, 8, 400);
      check_frame(0, 8, 7, c, D0);
      check("mrst_valid_edge", vcyc[0][7] - t, 265);

      // Minimum divider and gap: free-run three frames with a random channel.
      c = 1'($urandom_range(0, 1));
      cont[1] = 1'b1;
      start_frame(1, c, t);
      wait_valid(1, 1, 200);
      check("fast_valid_edge", vcyc[1][0] - t, 67);
      wait_valid(1, 2, 200);
      step(10);
      cont[1] = 1'b0;
      wait_valid(1, 3, 200);
      step(20);
      check("fast_frames", fs[1], 3);
      check("fast_valids", vc[1], 3);
      check("fast_busy_end", busy[1], 1'b0);
      for (int f = 0; f < 3; f++) check_frame(1, f, f, c, D1);
      check("fast_spacing_a", vcyc[1][1] - vcyc[1][0], 69);
      check("fast_spacing_b", vcyc[1][2] - vcyc[1][1], 69);
      check("fast_cs_high", (gap[1][1] >= I1 + 1), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
